// File: rtl/prefix_adder_pkg.sv
// Shared width constants for the 8-bit Kogge-Stone prefix adder.
// The prefix depth is log2 of the operand width.
package prefix_adder_pkg;
    localparam int ADDER_WIDTH   = 8;
    localparam int PREFIX_LEVELS = 3;
    localparam int SUM_WIDTH     = ADDER_WIDTH + 1;
endpackage

// File: rtl/prefix_gp_cell.sv
// Kogge-Stone combine cell: merges a higher (i) group with a lower (j) group
// into one generate/propagate pair.
module prefix_gp_cell (
    input  logic Gi,
    input  logic Pi,
    input  logic Gj,
    input  logic Pj,
    output logic G,
    output logic P
);
    assign G = Gi | (Pi & Gj);
    assign P = Pi & Pj;
endmodule

// File: rtl/prefix_adder_8bit.sv
// Registered 8-bit unsigned adder on a Kogge-Stone carry network; the 9-bit
// result appears one clock after the operands are sampled.
module prefix_adder_8bit
    import prefix_adder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ADDER_WIDTH-1:0] A,
    input  logic [ADDER_WIDTH-1:0] B,
    output logic [SUM_WIDTH-1:0]   Sum
);
    // Level 0 holds the bitwise g/p; level k holds group terms spanning 2**k bits.
    logic [PREFIX_LEVELS:0][ADDER_WIDTH-1:0] g_lvl;
    logic [PREFIX_LEVELS:0][ADDER_WIDTH-1:0] p_lvl;
    logic [ADDER_WIDTH-1:0]                  carry;
    logic [SUM_WIDTH-1:0]                    sum_next;
    logic                                    unused_p;

    assign g_lvl[0] = A & B;
    assign p_lvl[0] = A ^ B;

    for (genvar lvl = 0; lvl < PREFIX_LEVELS; lvl++) begin : g_level
        localparam int SPAN = 1 << lvl;
        for (genvar i = 0; i < ADDER_WIDTH; i++) begin : g_bit
            if (i < SPAN) begin : g_pass
                assign g_lvl[lvl+1][i] = g_lvl[lvl][i];
                assign p_lvl[lvl+1][i] = p_lvl[lvl][i];
            end else begin : g_cell
                prefix_gp_cell u_cell (
                    .Gi (g_lvl[lvl][i]),
                    .Pi (p_lvl[lvl][i]),
                    .Gj (g_lvl[lvl][i-SPAN]),
                    .Pj (p_lvl[lvl][i-SPAN]),
                    .G  (g_lvl[lvl+1][i]),
                    .P  (p_lvl[lvl+1][i])
                );
            end
        end
    end

    // After the last level, g_lvl[LAST][i] is the group generate over bits 0..i.
    assign carry    = {g_lvl[PREFIX_LEVELS][ADDER_WIDTH-2:0], 1'b0};
    assign sum_next = {g_lvl[PREFIX_LEVELS][ADDER_WIDTH-1], p_lvl[0] ^ carry};

    // Final-level group propagates have no consumer.
    assign unused_p = ^p_lvl[PREFIX_LEVELS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Sum <= '0;
        end else begin
            Sum <= sum_next;
        end
    end
endmodule

// File: tb/tb_prefix_adder_8bit.sv
// Bench for prefix_adder_8bit: directed corner cases, async reset behaviour,
// random regression and an exhaustive operand sweep against an arithmetic model.
module tb_prefix_adder_8bit;
    logic       clk;
    logic       rst;
    logic [7:0] A;
    logic [7:0] B;
    logic [8:0] Sum;

    int total = 0;
    int bad   = 0;
    logic [8:0] exp_q[$];

    prefix_adder_8bit dut (
        .clk (clk),
        .rst (rst),
        .A   (A),
        .B   (B),
        .Sum (Sum)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
        int unsigned s;
        s = int'(a) + int'(b);
        return s[8:0];
    endfunction

    // driver: present operands, step one edge, settle just after it
    task automatic drive_cycle(input logic [7:0] a, input logic [7:0] b);
        A = a;
        B = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        A = 8'hFF;
        B = 8'hFF;
        #1;
        total++;
        if (Sum !== 9'h000) begin
            bad++;
            $display("FAIL reset_t0 got=%h want=%h", Sum, 9'h000);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (Sum !== 9'h000) begin
                bad++;
                $display("FAIL reset_hold[%0d] got=%h want=%h", k, Sum, 9'h000);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (Sum !== 9'h1FE) begin
            bad++;
            $display("FAIL reset_release got=%h want=%h", Sum, 9'h1FE);
        end
    endtask

    task automatic test_directed();
        logic [7:0] ta [5];
        logic [7:0] tb [5];
        logic [8:0] te [5];
        ta = '{8'hDA, 8'h55, 8'h00, 8'hFF, 8'h80};
        tb = '{8'hA7, 8'hAA, 8'h00, 8'h01, 8'h80};
        te = '{9'h181, 9'h0FF, 9'h000, 9'h100, 9'h100};
        for (int k = 0; k < 5; k++) begin
            drive_cycle(ta[k], tb[k]);
            total++;
            if (Sum !== te[k]) begin
                bad++;
                $display("FAIL directed[%0d] A=%h B=%h got=%h want=%h", k, ta[k], tb[k], Sum, te[k]);
            end
        end
    endtask

    task automatic test_hold();
        drive_cycle(8'h3C, 8'h4D);
        A = 8'h01;
        B = 8'h01;
        #3;
        total++;
        if (Sum !== 9'h089) begin
            bad++;
            $display("FAIL hold_midcycle got=%h want=%h", Sum, 9'h089);
        end
        @(posedge clk);
        #1;
        total++;
        if (Sum !== 9'h002) begin
            bad++;
            $display("FAIL hold_next_edge got=%h want=%h", Sum, 9'h002);
        end
    endtask

    task automatic test_async_reset();
        drive_cycle(8'hDA, 8'hA7);
        total++;
        if (Sum !== 9'h181) begin
            bad++;
            $display("FAIL async_pre got=%h want=%h", Sum, 9'h181);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (Sum !== 9'h000) begin
            bad++;
            $display("FAIL async_clear got=%h want=%h", Sum, 9'h000);
        end
        #1;
        rst = 1'b0;
        #1;
        total++;
        if (Sum !== 9'h000) begin
            bad++;
            $display("FAIL async_after_release got=%h want=%h", Sum, 9'h000);
        end
        @(posedge clk);
        #1;
        total++;
        if (Sum !== 9'h181) begin
            bad++;
            $display("FAIL async_recapture got=%h want=%h", Sum, 9'h181);
        end
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        logic [8:0] exp_v;
        for (int k = 0; k < 1000; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            exp_q.push_back(model(a, b));
            drive_cycle(a, b);
            exp_v = exp_q.pop_front();
            total++;
            if (Sum !== exp_v) begin
                bad++;
                $display("FAIL random[%0d] A=%h B=%h got=%h want=%h", k, a, b, Sum, exp_v);
            end
        end
    endtask

    task automatic test_exhaustive();
        logic [8:0] exp_v;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                exp_q.push_back(model(8'(a), 8'(b)));
                drive_cycle(8'(a), 8'(b));
                exp_v = exp_q.pop_front();
                total++;
                if (Sum !== exp_v) begin
                    bad++;
                    $display("FAIL sweep A=%h B=%h got=%h want=%h", a[7:0], b[7:0], Sum, exp_v);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_async_reset();
        test_random();
        test_exhaustive();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
